// File: rtl/hazard_control.sv
// Pipeline hazard control: load-use interlock, branch flush and data-cache miss stall FSM.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_access_valid,
  input  logic        dcache_hit,
  input  logic        dcache_fill_done,
  output logic        takebranch,
  output logic        stall,
  output logic        load_use_stall,
  output logic        dcache_stall,
  output logic        miss_timeout,
  output logic [31:0] perf_load_use_cnt,
  output logic [31:0] perf_dcache_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [1:0] {IDLE, MISS_WAIT, RESUME} miss_state_t;

  miss_state_t state, state_next;
  logic [7:0]  wait_cnt;
  logic        miss_seen;
  logic        rd_match;

  always_comb begin
    state_next   = state;
    dcache_stall = 1'b0;
    miss_seen    = mem_access_valid & ~dcache_hit;
    case (state)
      IDLE: begin
        if (miss_seen) begin
          dcache_stall = 1'b1;
          state_next   = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        dcache_stall = 1'b1;
        if (dcache_fill_done) state_next = RESUME;
      end
      // One-cycle window where a fresh miss is deliberately not seen.
      RESUME:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (reset) dcache_stall = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt     <= 8'd0;
      miss_timeout <= 1'b0;
    end else begin
      if (state == IDLE && state_next == MISS_WAIT)
        wait_cnt <= 8'd0;
      else if (state == MISS_WAIT && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
      // Set on the same edge the counter lands on 255; sticky until reset.
      if (state == MISS_WAIT && wait_cnt == 8'hFE)
        miss_timeout <= 1'b1;
    end
  end

  assign rd_match = (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));

  assign takebranch     = ex_branch_taken & ~dcache_stall & ~reset;
  assign load_use_stall = ex_is_load & rd_match & ~dcache_stall & ~ex_branch_taken & ~reset;
  assign stall          = dcache_stall | load_use_stall;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && v != 32'hFFFF_FFFF) return v + 32'd1;
    return v;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_load_use_cnt     <= 32'd0;
      perf_dcache_stall_cnt <= 32'd0;
      perf_flush_cnt        <= 32'd0;
    end else begin
      perf_load_use_cnt     <= sat_inc(perf_load_use_cnt, load_use_stall);
      perf_dcache_stall_cnt <= sat_inc(perf_dcache_stall_cnt, dcache_stall);
      perf_flush_cnt        <= sat_inc(perf_flush_cnt, takebranch);
    end
  end
`else
  assign perf_load_use_cnt     = 32'd0;
  assign perf_dcache_stall_cnt = 32'd0;
  assign perf_flush_cnt        = 32'd0;
`endif

endmodule
